// File: rtl/col_pack_if.sv
// Stream bus for col_pack: raster-order pixel input and column-order output.
// The master drives pixels and clear; the slave returns packed 2-row columns.
interface col_pack_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_MATS     = 10,
  parameter int MAT_W      = 2
);
  localparam int CW = (MAT_W > 1) ? $clog2(MAT_W) : 1;

  logic                                    clear;
  logic                                    valid_in;
  logic [N_MATS-1:0][DATA_WIDTH-1:0]       pixel;
  logic [N_MATS-1:0][1:0][DATA_WIDTH-1:0]  column;
  logic                                    valid_out;
  logic [CW-1:0]                           col_idx;
  logic                                    frame_done;

  modport master (
    output clear, valid_in, pixel,
    input  column, valid_out, col_idx, frame_done
  );

  modport slave (
    input  clear, valid_in, pixel,
    output column, valid_out, col_idx, frame_done
  );
endinterface

// File: rtl/col_pack.sv
// Raster-to-column packer: buffers row 0 of every map, then pairs each row-1
// pixel with its buffered row-0 partner and emits the 2-element column.
module col_pack_lane #(
  parameter int DW    = 16,
  parameter int MAT_W = 2,
  parameter int CW    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                emit,
  input  logic [CW-1:0]       idx,
  input  logic [DW-1:0]       pixel,
  output logic [1:0][DW-1:0]  column
);
  // Depth padded to 2 so a 1-bit index always covers the array when MAT_W=1.
  localparam int LB = (MAT_W < 2) ? 2 : MAT_W;

  logic [LB-1:0][DW-1:0] linebuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      linebuf <= '0;
      column  <= '0;
    end else begin
      if (wr_en) linebuf[idx] <= pixel;
      if (emit) begin
        column[0] <= linebuf[idx];
        column[1] <= pixel;
      end
    end
  end
endmodule

module col_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int N_MATS     = 10,
  parameter int MAT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  col_pack_if.slave   bus
);
  localparam int            CW   = (MAT_W > 1) ? $clog2(MAT_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAT_W - 1);

  typedef enum logic { FILL = 1'b0, EMIT = 1'b1 } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col_cnt, cnt_nxt;
  logic          wr_en, emit, last;
  logic [1:0]    vld_pipe;

  assign last = (col_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      col_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= cnt_nxt;
    end
  end

  // clear outranks valid_in; the pixel offered alongside it is dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = col_cnt;
    wr_en     = 1'b0;
    emit      = 1'b0;
    if (bus.clear) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (bus.valid_in) begin
      cnt_nxt = last ? '0 : col_cnt + CW'(1);
      case (state)
        FILL: begin
          wr_en = 1'b1;
          if (last) state_nxt = EMIT;
        end
        EMIT: begin
          emit = 1'b1;
          if (last) state_nxt = FILL;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  assign vld_pipe[0] = emit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[1]    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.col_idx    <= '0;
    end else begin
      vld_pipe[1]    <= vld_pipe[0];
      bus.frame_done <= emit & last;
      if (emit) bus.col_idx <= col_cnt;
    end
  end

  assign bus.valid_out = vld_pipe[1];

  logic [N_MATS-1:0][1:0][DATA_WIDTH-1:0] col_w;

  for (genvar g = 0; g < N_MATS; g++) begin : g_lane
    col_pack_lane #(.DW(DATA_WIDTH), .MAT_W(MAT_W), .CW(CW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .emit   (emit),
      .idx    (col_cnt),
      .pixel  (bus.pixel[g]),
      .column (col_w[g])
    );
  end

  assign bus.column = col_w;
endmodule
